// File: rtl/emulador_teclado_if.sv
// Keypad emulator bus: scanner row/column lines plus the key request handshake.
interface emulador_teclado_if;
  logic [3:0] fila;
  logic [3:0] col;
  logic [4:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output fila, key_code, key_valid,
    input  col, key_ready, busy, done, err
  );

  modport slave (
    input  fila, key_code, key_valid,
    output col, key_ready, busy, done, err
  );
endinterface

// File: rtl/emulador_teclado.sv
// 4x4 matrix keypad emulator: presses a requested key for HOLD_CYC cycles, then releases it for GAP_CYC.
// Optional macro KEY_BOUNCE_EN adds contact bounce over the first BOUNCE_CYC cycles of each press.
//
// state   | meaning
// IDLE    | waiting for a request, key_ready high
// PRESS   | latched key closed (subject to bounce), col answers fila
// RELEASE | forced open time before the next request
module emulador_teclado #(
  parameter int HOLD_CYC   = 16,
  parameter int GAP_CYC    = 8,
  parameter int BOUNCE_CYC = 6
) (
  input logic               clk,
  input logic               rst,
  emulador_teclado_if.slave bus
);

  localparam int MAX_HG  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int MAX_CYC = (MAX_HG > BOUNCE_CYC) ? MAX_HG : BOUNCE_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    row_q;
  logic [3:0]    col_q;
  logic          done_q;
  logic          err_q;
  logic [7:0]    pos_n;
  logic          accept;
  logic          contact;

  // {row, col} one-hot position of each hex key on the pad
  always_comb begin
    pos_n = 8'h00;
    case (bus.key_code[3:0])
      4'h1: pos_n = {4'b0001, 4'b0001};
      4'h2: pos_n = {4'b0001, 4'b0010};
      4'h3: pos_n = {4'b0001, 4'b0100};
      4'hA: pos_n = {4'b0001, 4'b1000};
      4'h4: pos_n = {4'b0010, 4'b0001};
      4'h5: pos_n = {4'b0010, 4'b0010};
      4'h6: pos_n = {4'b0010, 4'b0100};
      4'hB: pos_n = {4'b0010, 4'b1000};
      4'h7: pos_n = {4'b0100, 4'b0001};
      4'h8: pos_n = {4'b0100, 4'b0010};
      4'h9: pos_n = {4'b0100, 4'b0100};
      4'hC: pos_n = {4'b0100, 4'b1000};
      4'hF: pos_n = {4'b1000, 4'b0001};
      4'h0: pos_n = {4'b1000, 4'b0010};
      4'hE: pos_n = {4'b1000, 4'b0100};
      4'hD: pos_n = {4'b1000, 4'b1000};
      default: pos_n = 8'h00;
    endcase
  end

`ifdef KEY_BOUNCE_EN
  logic [CW-1:0] press_idx;
  assign press_idx = CW'(HOLD_CYC - 1) - cnt;
  assign contact   = !((press_idx < CW'(BOUNCE_CYC)) && press_idx[0]);
`else
  assign contact = 1'b1;
`endif

  assign accept        = bus.key_valid && bus.key_ready;
  assign bus.key_ready = (state == IDLE) && !rst;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  // Zero-latency return path: the scanner samples col in the cycle it drives fila.
  // row_q is one-hot whenever PRESS is active, so an empty or multi-bit fila never matches.
  assign bus.col = ((state == PRESS) && contact && (bus.fila == row_q)) ? col_q : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      row_q  <= 4'b0000;
      col_q  <= 4'b0000;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!bus.key_code[4]) begin
              row_q <= pos_n[7:4];
              col_q <= pos_n[3:0];
              cnt   <= CW'(HOLD_CYC - 1);
              state <= PRESS;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        PRESS: begin
          if (cnt == '0) begin
            cnt   <= CW'(GAP_CYC - 1);
            state <= RELEASE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RELEASE: begin
          if (cnt == '0) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_emulador_teclado.sv
// Testbench for emulador_teclado: directed keypad scenarios plus random traffic vs. a timeline model.
module tb_emulador_teclado;
  localparam int HOLD   = 16;
  localparam int GAP    = 8;
  localparam int BOUNCE = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  emulador_teclado_if bus ();

  emulador_teclado #(
    .HOLD_CYC  (HOLD),
    .GAP_CYC   (GAP),
    .BOUNCE_CYC(BOUNCE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;
  int done_seen = 0;

  // Model: a key press is a timeline measured in cycles since acceptance
  bit m_active = 1'b0;
  int m_t      = 0;
  int m_row    = 0;
  int m_col    = 0;
  bit m_done   = 1'b0;
  bit m_err    = 1'b0;

  int keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{15, 0, 14, 13}};

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s t=%0t observed %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] ec;
    bit contact;
    #1;
    if (chk_en) begin
      ec = 4'b0000;
      contact = 1'b1;
`ifdef KEY_BOUNCE_EN
      if (m_t < BOUNCE && (m_t % 2) == 1) contact = 1'b0;
`endif
      if (m_active && m_t < HOLD && contact && bus.fila == 4'(1 << m_row)) ec = 4'(1 << m_col);
      check("col", 32'(bus.col), 32'(ec));
      check("key_ready", 32'(bus.key_ready), 32'(!m_active && !rst));
      check("busy", 32'(bus.busy), 32'(m_active));
      check("done", 32'(bus.done), 32'(m_done));
      check("err", 32'(bus.err), 32'(m_err));
    end
    if (bus.done === 1'b1) done_seen++;
    @(posedge clk);
    if (rst) begin
      m_active = 1'b0; m_t = 0; m_done = 1'b0; m_err = 1'b0;
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (m_active) begin
        m_t++;
        if (m_t == HOLD + GAP) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end else if (bus.key_valid) begin
        if (bus.key_code < 16) begin
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
              if (keymap[r][c] == int'(bus.key_code)) begin
                m_row = r; m_col = c;
              end
          m_active = 1'b1;
          m_t = 0;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic req(int code);
    bus.key_valid = 1'b1;
    bus.key_code  = 5'(code);
    tick();
    bus.key_valid = 1'b0;
    bus.key_code  = 5'($urandom_range(0, 31));
  endtask

  task automatic rtick();
    case ($urandom_range(0, 5))
      0: bus.fila = 4'b0000;
      1, 2: bus.fila = 4'(1 << m_row);
      3, 4: bus.fila = 4'(1 << $urandom_range(0, 3));
      default: bus.fila = 4'($urandom_range(0, 15));
    endcase
    tick();
  endtask

  initial begin
    bus.fila = 4'b0000;
    bus.key_valid = 1'b0;
    bus.key_code = 5'd0;
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // key 5 (row 2, col 2), scanning all rows
    bus.fila = 4'b0010;
    done_seen = 0;
    req(5);
    for (int i = 0; i < HOLD + GAP + 2; i++) begin
      bus.fila = (i % 2 == 0) ? 4'b0010 : 4'(1 << (i % 4));
      tick();
    end
    check("done_cnt_k5", 32'(done_seen), 32'd1);

    // keys 0 and D share row 4
    bus.fila = 4'b1000;
    req(0);
    run(HOLD + GAP + 1);
    req(13);
    run(HOLD + GAP + 1);

    // invalid code
    req(17);
    for (int i = 0; i < 4; i++) rtick();

    // second request during PRESS is ignored
    done_seen = 0;
    bus.fila = 4'b0100;
    req(9);
    run(3);
    bus.key_valid = 1'b1;
    bus.key_code  = 5'd1;
    tick();
    bus.key_valid = 1'b0;
    run(HOLD + GAP + 2);
    check("done_cnt_k9", 32'(done_seen), 32'd1);

    // reset on PRESS cycle 5 of key A
    done_seen = 0;
    bus.fila = 4'b0001;
    req(10);
    run(5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(HOLD + GAP + 2);
    check("done_cnt_abort", 32'(done_seen), 32'd0);

    // key 2 on row 1 (bounce pattern visible when enabled), then back-to-back
    bus.fila = 4'b0001;
    req(2);
    run(HOLD + GAP);
    req(3);
    run(HOLD + GAP);
    req(8);
    run(HOLD + GAP + 2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.key_valid = ($urandom_range(0, 5) == 0);
      bus.key_code  = 5'($urandom_range(0, 31));
      rst = ($urandom_range(0, 199) == 0);
      rtick();
    end
    rst = 1'b0;
    bus.key_valid = 1'b0;
    run(HOLD + GAP + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
